bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch master (M0) and data master (M1).
- Sits between the two bus_master instances and the single unified memory slave.
- Fixed priority favours M1 (data). An anti-starvation counter guarantees M0 forward progress.
- Supports one outstanding transaction, with a response timeout that produces a bus error.

Parameters:
- STARVE_MAX, 4: consecutive cycles M0 may be denied before it is forced to win the next grant.
- TIMEOUT, 16: cycles in WAIT_RESP without s_valid before the arbiter aborts with an error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_en  in  1  M0 request
- m0_we  in  1  M0 write
- m0_addr  in  30  M0 word address
- m0_wdata  in  32  M0 write data
- m0_mask  in  4  M0 byte mask
- m0_rdata  out  32  M0 read data
- m0_valid  out  1  M0 response valid
- m0_stall  out  1  M0 request not accepted this cycle
- m0_err  out  1  M0 error
- m1_*  same set as m0_*  data master
- s_en  out  1  slave request
- s_we  out  1  slave write
- s_addr  out  30  slave word address
- s_wdata  out  32  slave write data
- s_mask  out  4  slave byte mask
- s_rdata  in  32  slave read data
- s_valid  in  1  slave response valid
- s_stall  in  1  slave cannot accept request
- s_err  in  1  slave error, qualified by s_valid
- owner  out  1  master owning the outstanding transaction (0/1), for debug/ILA

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- State machine: IDLE, WAIT_RESP. Registers: state, owner, starve_cnt (clog2(STARVE_MAX+1) bits), tmo_cnt (clog2(TIMEOUT+1) bits).
- Reset values: state=IDLE, owner=0, starve_cnt=0, tmo_cnt=0.
- Outputs while rst=1: s_en=0, m*_valid=0, m*_err=0, m*_stall=0, m*_rdata=0.
- Grant (combinational, IDLE only):
  - gnt1 = m1_en & ~(m0_en & starve_cnt==STARVE_MAX).
  - gnt0 = m0_en & ~gnt1.
- Slave drive:
  - s_en = (IDLE) & (m0_en|m1_en).
  - s_we/s_addr/s_wdata/s_mask are muxed from the granted master.
  - In WAIT_RESP: s_en=0, other slave outputs are don't-care (drive 0).
- Acceptance: accept = s_en & ~s_stall.
- Stalls:
  - m*_stall = m*_en & ~(granted & accept).
  - Any request in WAIT_RESP is stalled.
  - A non-requesting master never sees stall.
- IDLE -> WAIT_RESP on accept: owner <= granted index, tmo_cnt <= 0.
- A same-cycle s_valid while in IDLE is ignored. The slave response latency is at least 1 cycle.
- WAIT_RESP behaviour:
  - tmo_cnt increments each cycle.
  - On s_valid: m[owner]_valid=1, m[owner]_rdata=s_rdata, m[owner]_err=s_err, state <= IDLE.
  - The new request can be granted on the cycle after the response (no same-cycle turnaround).
- Timeout:
  - If tmo_cnt==TIMEOUT-1 and ~s_valid: m[owner]_valid=1, m[owner]_err=1, rdata=0, state <= IDLE.
  - A late s_valid arriving in IDLE is dropped.
- Writes receive an s_valid response exactly like reads. m*_valid is a single-cycle pulse.
- The non-owner master's valid/err/rdata are always 0.
- starve_cnt:
  - Updated only in IDLE.
  - Resets to 0 when M0 is accepted or m0_en=0.
  - Increments (saturating at STARVE_MAX) when m0_en=1 and M0 is not accepted.
  - Held in WAIT_RESP.
- Simultaneous events:
  - Both request with s_stall=1: nobody is accepted, the granted master's signals are held on s_*, both masters are stalled, and starve_cnt counts.
  - Grant may change between cycles while stalled. The slave must sample only on accept.
- Reset mid-transaction: rst in WAIT_RESP returns to IDLE next edge, and no valid is issued for the lost transaction.

Test Plan:
- M0 only, read addr 0x100, slave returns 0xDEADBEEF after 2 cycles -> m0_stall=0 on the request cycle, s_addr=0x100, m0_valid pulses with rdata 0xDEADBEEF 2 cycles later, owner=0.
- Both request every cycle, slave latency 1, STARVE_MAX=4 -> M1 accepted 4 times, then M0 accepted once, pattern repeats; starve_cnt never exceeds 4.
- M1 write mask 0x3 addr 0x40 data 0x1234 with s_stall=1 for 3 cycles -> m1_stall=1 for 3 cycles, s_* held stable, accept on 4th cycle, m1_valid=1 on response.
- Slave never responds, TIMEOUT=16 -> m1_valid=1 & m1_err=1 exactly 16 cycles after accept, rdata=0, state IDLE; a late s_valid is ignored.
- Slave returns s_valid with s_err=1 for an M0 fetch -> m0_err=1, m0_valid=1, m1 outputs all 0.
- rst asserted in WAIT_RESP -> next cycle state IDLE, no valid pulses, s_en follows the new request only after rst deasserts.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/response memory bus between a master and the arbiter or slave
interface bus_arbiter_if;
    logic        en;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        valid;
    logic        stall;
    logic        err;

    modport master (
        output en, we, addr, wdata, mask,
        input  rdata, valid, stall, err
    );

    modport slave (
        input  en, we, addr, wdata, mask,
        output rdata, valid, stall, err
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master single-outstanding memory arbiter with M0 anti-starvation and response timeout
module bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_if.slave   m0,
    bus_arbiter_if.slave   m1,
    bus_arbiter_if.master  s,
    output logic           owner
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, WAIT_RESP = 1'b1} state_t;

    state_t          state, state_nx;
    logic            owner_nx;
    logic [SW-1:0]   starve_cnt, starve_nx;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    logic            gnt0, gnt1, accept;
    logic            resp, resp_err;
    logic [31:0]     resp_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            starve_cnt <= starve_nx;
            tmo_cnt    <= tmo_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        starve_nx  = starve_cnt;
        tmo_nx     = tmo_cnt;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        accept     = 1'b0;
        resp       = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        s.en       = 1'b0;
        s.we       = 1'b0;
        s.addr     = '0;
        s.wdata    = '0;
        s.mask     = '0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    // M1 wins unless M0 has been denied long enough to be forced through
                    gnt1 = m1.en & ~(m0.en & (starve_cnt == STARVE_LIM));
                    gnt0 = m0.en & ~gnt1;
                    s.en = m0.en | m1.en;
                    if (gnt1) begin
                        s.we    = m1.we;
                        s.addr  = m1.addr;
                        s.wdata = m1.wdata;
                        s.mask  = m1.mask;
                    end else if (gnt0) begin
                        s.we    = m0.we;
                        s.addr  = m0.addr;
                        s.wdata = m0.wdata;
                        s.mask  = m0.mask;
                    end
                    accept = s.en & ~s.stall;
                    if (accept) begin
                        state_nx = WAIT_RESP;
                        owner_nx = gnt1;
                        tmo_nx   = '0;
                    end
                    if (m0.en & ~(gnt0 & accept))
                        starve_nx = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + SW'(1);
                    else
                        starve_nx = '0;
                end
                WAIT_RESP: begin
                    tmo_nx = tmo_cnt + TW'(1);
                    if (s.valid) begin
                        resp       = 1'b1;
                        resp_err   = s.err;
                        resp_rdata = s.rdata;
                        state_nx   = IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp     = 1'b1;
                        resp_err = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        m0.stall = ~rst & m0.en & ~(gnt0 & accept);
        m1.stall = ~rst & m1.en & ~(gnt1 & accept);
        m0.valid = resp & ~owner;
        m1.valid = resp & owner;
        m0.err   = resp & resp_err & ~owner;
        m1.err   = resp & resp_err & owner;
        m0.rdata = (resp & ~owner) ? resp_rdata : '0;
        m1.rdata = (resp & owner)  ? resp_rdata : '0;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic clk = 1'b0;
    logic rst;
    logic owner;
    always #5 clk = ~clk;

    bus_arbiter_if m0_bus();
    bus_arbiter_if m1_bus();
    bus_arbiter_if s_bus();

    bus_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .owner(owner)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: is a transaction outstanding, who owns it, cycles since it was accepted,
    // and how many consecutive cycles M0 has asked without being accepted.
    bit mb_busy = 0;
    bit mb_owner = 0;
    int mb_age = 0;
    int mb_denied = 0;
    bit acc_flag;
    logic [138:0] exp_vec, obs;

    function automatic logic [138:0] observe();
        return {s_bus.en, s_bus.we, s_bus.addr, s_bus.wdata, s_bus.mask,
                m0_bus.rdata, m0_bus.valid, m0_bus.stall, m0_bus.err,
                m1_bus.rdata, m1_bus.valid, m1_bus.stall, m1_bus.err, owner};
    endfunction

    function automatic void model_step();
        logic        e_sen, e_swe, v0, v1, st0, st1, er0, er1, re, e_owner;
        logic [29:0] e_addr;
        logic [31:0] e_wd, r0, r1, rv;
        logic [3:0]  e_mask;
        int          win;
        e_sen = 0; e_swe = 0; e_addr = '0; e_wd = '0; e_mask = '0;
        v0 = 0; v1 = 0; st0 = 0; st1 = 0; er0 = 0; er1 = 0; r0 = '0; r1 = '0;
        e_owner = mb_owner;
        win = -1;
        acc_flag = 0;
        if (rst) begin
            mb_busy = 0; mb_owner = 0; mb_denied = 0;
        end else if (!mb_busy) begin
            if (m1_bus.en && !(m0_bus.en && mb_denied >= STARVE_MAX)) win = 1;
            else if (m0_bus.en) win = 0;
            if (win == 1) {e_swe, e_addr, e_wd, e_mask} = {m1_bus.we, m1_bus.addr, m1_bus.wdata, m1_bus.mask};
            else if (win == 0) {e_swe, e_addr, e_wd, e_mask} = {m0_bus.we, m0_bus.addr, m0_bus.wdata, m0_bus.mask};
            e_sen = (win >= 0);
            acc_flag = e_sen && !s_bus.stall;
            st0 = m0_bus.en && !(acc_flag && win == 0);
            st1 = m1_bus.en && !(acc_flag && win == 1);
            mb_denied = st0 ? ((mb_denied < STARVE_MAX) ? mb_denied + 1 : STARVE_MAX) : 0;
            if (acc_flag) begin
                mb_busy = 1; mb_owner = (win == 1); mb_age = 0;
            end
        end else begin
            st0 = m0_bus.en;
            st1 = m1_bus.en;
            mb_age++;
            if (s_bus.valid || mb_age == TIMEOUT) begin
                rv = s_bus.valid ? s_bus.rdata : 32'h0;
                re = s_bus.valid ? s_bus.err : 1'b1;
                if (mb_owner) {v1, r1, er1} = {1'b1, rv, re};
                else          {v0, r0, er0} = {1'b1, rv, re};
                mb_busy = 0;
            end
        end
        exp_vec = {e_sen, e_swe, e_addr, e_wd, e_mask, r0, v0, st0, er0, r1, v1, st1, er1, e_owner};
    endfunction

    task automatic tick();
        #1;
        model_step();
        obs = observe();
    endtask

    task automatic set_m0(input logic en, input logic we, input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        m0_bus.en = en; m0_bus.we = we; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.mask = m;
    endtask

    task automatic set_m1(input logic en, input logic we, input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        m1_bus.en = en; m1_bus.we = we; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.mask = m;
    endtask

    task automatic set_s(input logic stall, input logic valid, input logic [31:0] rd, input logic err);
        s_bus.stall = stall; s_bus.valid = valid; s_bus.rdata = rd; s_bus.err = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_m0(1'($urandom), 1'($urandom), 30'($urandom), $urandom, 4'($urandom));
            set_m1(1'($urandom), 1'($urandom), 30'($urandom), $urandom, 4'($urandom));
            set_s(1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            tick();
            if (obs !== exp_vec) begin miscompares++; $display("FAIL reset_model: got %h expected %h", obs, exp_vec); end
            vectors++;
            if ({s_bus.en, m0_bus.valid, m1_bus.valid, m0_bus.stall, m1_bus.stall, m0_bus.err, m1_bus.err, m0_bus.rdata, m1_bus.rdata} !== 71'h0) begin
                miscompares++; $display("FAIL reset_outputs: s_en=%b v0=%b v1=%b st0=%b st1=%b required all 0", s_bus.en, m0_bus.valid, m1_bus.valid, m0_bus.stall, m1_bus.stall);
            end
            vectors++;
            @(negedge clk);
        end
        rst = 1'b0;
        set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
        tick();
        if (owner !== 1'b0) begin miscompares++; $display("FAIL reset_owner: got %b required 0", owner); end
        vectors++;
        @(negedge clk);
    endtask

    task automatic test_m0_read();
        set_m0(1, 0, 30'h100, 32'h0, 4'hF);
        tick();
        if (obs !== exp_vec) begin miscompares++; $display("FAIL m0_read_req: got %h expected %h", obs, exp_vec); end
        vectors++;
        if ({m0_bus.stall, s_bus.en, s_bus.addr} !== {1'b0, 1'b1, 30'h100}) begin
            miscompares++; $display("FAIL m0_read_accept: stall=%b s_en=%b s_addr=%h required 0 1 100", m0_bus.stall, s_bus.en, s_bus.addr);
        end
        vectors++;
        @(negedge clk);
        set_m0(0, 0, 0, 0, 0);
        tick();
        if (obs !== exp_vec) begin miscompares++; $display("FAIL m0_read_wait: got %h expected %h", obs, exp_vec); end
        vectors++;
        @(negedge clk);
        set_s(0, 1, 32'hDEADBEEF, 0);
        tick();
        if ({m0_bus.valid, m0_bus.rdata, owner, m1_bus.valid} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL m0_read_resp: valid=%b rdata=%h owner=%b required 1 deadbeef 0", m0_bus.valid, m0_bus.rdata, owner);
        end
        vectors++;
        @(negedge clk);
        set_s(0, 0, 0, 0);
        tick();
        if (obs !== exp_vec) begin miscompares++; $display("FAIL m0_read_pulse: got %h expected %h", obs, exp_vec); end
        vectors++;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int  k = 0;
        bit  acc_prev = 0;
        int  who, pat;
        set_m0(1, 0, 30'h10, 0, 4'hF);
        set_m1(1, 0, 30'h20, 0, 4'hF);
        for (int c = 0; c < 30; c++) begin
            set_s(0, acc_prev, 32'h1000 + 32'(c), 0);
            tick();
            if (obs !== exp_vec) begin miscompares++; $display("FAIL starve_model cyc%0d: got %h expected %h", c, obs, exp_vec); end
            vectors++;
            acc_prev = s_bus.en && !s_bus.stall;
            if (acc_prev) begin
                who = m1_bus.stall ? 0 : 1;
                pat = (k % 5 == 4) ? 0 : 1;
                if (who !== pat) begin miscompares++; $display("FAIL starve_order grant%0d: got M%0d required M%0d", k, who, pat); end
                vectors++;
                k++;
            end
            @(negedge clk);
        end
        if (k < 10) begin miscompares++; $display("FAIL starve_progress: got %0d grants required >= 10", k); end
        vectors++;
        set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
        set_s(0, acc_prev, 32'h0, 0);
        tick();
        if (obs !== exp_vec) begin miscompares++; $display("FAIL starve_drain: got %h expected %h", obs, exp_vec); end
        vectors++;
        @(negedge clk);
        set_s(0, 0, 0, 0);
    endtask

    task automatic test_stall_write();
        set_m1(1, 1, 30'h40, 32'h1234, 4'h3);
        for (int c = 0; c < 4; c++) begin
            set_s(c < 3, 0, 0, 0);
            tick();
            if (obs !== exp_vec) begin miscompares++; $display("FAIL stall_model cyc%0d: got %h expected %h", c, obs, exp_vec); end
            vectors++;
            if ({m1_bus.stall, s_bus.en, s_bus.we, s_bus.addr, s_bus.wdata, s_bus.mask} !== {(c < 3) ? 1'b1 : 1'b0, 1'b1, 1'b1, 30'h40, 32'h1234, 4'h3}) begin
                miscompares++; $display("FAIL stall_hold cyc%0d: stall=%b en=%b we=%b addr=%h wdata=%h mask=%h", c, m1_bus.stall, s_bus.en, s_bus.we, s_bus.addr, s_bus.wdata, s_bus.mask);
            end
            vectors++;
            @(negedge clk);
        end
        set_m1(0, 0, 0, 0, 0);
        set_s(0, 1, 32'h5A5A, 0);
        tick();
        if ({m1_bus.valid, m1_bus.err, m0_bus.valid} !== 3'b100) begin
            miscompares++; $display("FAIL stall_resp: m1_valid=%b m1_err=%b m0_valid=%b required 1 0 0", m1_bus.valid, m1_bus.err, m0_bus.valid);
        end
        vectors++;
        @(negedge clk);
        set_s(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int  seen = 0;
        set_m1(1, 0, 30'($urandom), 0, 4'hF);
        tick();
        if (obs !== exp_vec) begin miscompares++; $display("FAIL tmo_accept: got %h expected %h", obs, exp_vec); end
        vectors++;
        @(negedge clk);
        set_m1(0, 0, 0, 0, 0);
        for (int n = 1; n <= 40 && seen == 0; n++) begin
            tick();
            if (obs !== exp_vec) begin miscompares++; $display("FAIL tmo_model n%0d: got %h expected %h", n, obs, exp_vec); end
            vectors++;
            if (m1_bus.valid === 1'b1) seen = n;
            else if (m1_bus.valid !== 1'b0) seen = -1;
            if (seen > 0 && {m1_bus.err, m1_bus.rdata} !== {1'b1, 32'h0}) begin
                miscompares++; $display("FAIL tmo_err: err=%b rdata=%h required 1 0", m1_bus.err, m1_bus.rdata);
            end
            vectors++;
            @(negedge clk);
        end
        if (seen != TIMEOUT) begin miscompares++; $display("FAIL tmo_latency: got %0d cycles required %0d", seen, TIMEOUT); end
        vectors++;
        set_s(0, 1, 32'hBAD0BAD0, 0);
        tick();
        if ({m0_bus.valid, m1_bus.valid} !== 2'b00) begin
            miscompares++; $display("FAIL tmo_late: m0_valid=%b m1_valid=%b required 0 0", m0_bus.valid, m1_bus.valid);
        end
        vectors++;
        @(negedge clk);
        set_s(0, 0, 0, 0);
    endtask

    task automatic test_slave_err();
        logic [31:0] rd;
        rd = $urandom;
        set_m0(1, 0, 30'h200, 0, 4'hF);
        tick();
        if (obs !== exp_vec) begin miscompares++; $display("FAIL err_req: got %h expected %h", obs, exp_vec); end
        vectors++;
        @(negedge clk);
        set_m0(0, 0, 0, 0, 0);
        set_s(0, 1, rd, 1);
        tick();
        if ({m0_bus.valid, m0_bus.err, m1_bus.valid, m1_bus.err, m1_bus.stall, m1_bus.rdata} !== {4'b1100, 1'b0, 32'h0}) begin
            miscompares++; $display("FAIL err_resp: m0 v=%b e=%b m1 v=%b e=%b rdata=%h", m0_bus.valid, m0_bus.err, m1_bus.valid, m1_bus.err, m1_bus.rdata);
        end
        vectors++;
        @(negedge clk);
        set_s(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        set_m0(1, 0, 30'h300, 0, 4'hF);
        tick();
        @(negedge clk);
        set_m0(0, 0, 0, 0, 0);
        set_m1(1, 0, 30'h304, 0, 4'hF);
        rst = 1'b1;
        tick();
        if ({s_bus.en, m0_bus.valid, m1_bus.valid} !== 3'b000) begin
            miscompares++; $display("FAIL rstmid_hold: s_en=%b v0=%b v1=%b required 0 0 0", s_bus.en, m0_bus.valid, m1_bus.valid);
        end
        vectors++;
        @(negedge clk);
        rst = 1'b0;
        set_s(0, 1, 32'hCAFE, 0);
        tick();
        if ({s_bus.en, s_bus.addr, m1_bus.stall, m0_bus.valid, m1_bus.valid} !== {1'b1, 30'h304, 3'b000}) begin
            miscompares++; $display("FAIL rstmid_idle: s_en=%b addr=%h st1=%b v0=%b v1=%b", s_bus.en, s_bus.addr, m1_bus.stall, m0_bus.valid, m1_bus.valid);
        end
        vectors++;
        @(negedge clk);
        set_m1(0, 0, 0, 0, 0);
        tick();
        if (obs !== exp_vec) begin miscompares++; $display("FAIL rstmid_resp: got %h expected %h", obs, exp_vec); end
        vectors++;
        @(negedge clk);
        set_s(0, 0, 0, 0);
        tick();
        @(negedge clk);
    endtask

    task automatic test_random();
        bit pending = 0;
        int due = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_m0($urandom_range(0, 3) != 0, 1'($urandom), 30'($urandom), $urandom, 4'($urandom));
            set_m1($urandom_range(0, 2) != 0, 1'($urandom), 30'($urandom), $urandom, 4'($urandom));
            if (pending) due--;
            if (pending && due == 0) begin
                set_s($urandom_range(0, 3) == 0, 1, $urandom, $urandom_range(0, 7) == 0);
                pending = 0;
            end else begin
                set_s($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom, 1'($urandom));
            end
            tick();
            if (obs !== exp_vec) begin miscompares++; $display("FAIL random cyc%0d: got %h expected %h", c, obs, exp_vec); end
            vectors++;
            if (rst) pending = 0;
            if (acc_flag) begin
                pending = 1;
                due = ($urandom_range(0, 9) == 0) ? 17 + $urandom_range(0, 3) : $urandom_range(1, 5);
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        set_s(0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_m0_read();
        test_starvation();
        test_stall_write();
        test_timeout();
        test_slave_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
